// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, index/data typedefs and the x0 constant
// for the multi-port register file slice.
package regfile_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int REG_WIDTH_DEF = 5;

  typedef logic [REG_WIDTH_DEF-1:0] reg_idx_t;
  typedef logic [WIDTH_DEF-1:0]     xlen_t;

  // Architectural register 0 always reads as zero.
  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus of the register file.
// Protocol: there is no valid/ready handshake. wr_en_i, iss_en_i and flush_i
// are single-cycle strobes sampled on the rising clock edge. A strobe counts
// only in the cycle in which it is high. Reads are combinational and have no
// qualifier, so rd_data_o and rd_busy_o follow rd_addr_i within the same
// cycle.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2
);
  localparam int NUM_REGS = 2 ** REG_WIDTH;

  logic [NUM_RD*REG_WIDTH-1:0] rd_addr_i;
  logic [NUM_RD*WIDTH-1:0]     rd_data_o;
  logic [NUM_RD-1:0]           rd_busy_o;
  logic [NUM_WR-1:0]           wr_en_i;
  logic [NUM_WR*REG_WIDTH-1:0] wr_addr_i;
  logic [NUM_WR*WIDTH-1:0]     wr_data_i;
  logic                        iss_en_i;
  logic [REG_WIDTH-1:0]        iss_rd_i;
  logic                        flush_i;
  logic [NUM_REGS-1:0]         busy_vec_o;

  // Pipeline side: drives indices and strobes, observes data and busy state.
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_rd_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_vec_o
  );

  // Register file side.
  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_rd_i, flush_i,
    output rd_data_o, rd_busy_o, busy_vec_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per architectural register.
// Priority per register: flush clears all, then issue sets (the issuing
// instruction is younger than any same-cycle writeback), then writeback clears.
// Bit 0 is never set.
module regfile_scoreboard #(
  parameter int REG_WIDTH = 5,
  parameter int NUM_WR    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_iss_en,
  input  logic [REG_WIDTH-1:0]        i_iss_rd,
  input  logic [NUM_WR-1:0]           i_wr_en,
  input  logic [NUM_WR*REG_WIDTH-1:0] i_wr_addr,
  input  logic                        i_flush,
  output logic [2**REG_WIDTH-1:0]     o_busy_vec
);
  localparam int NUM_REGS = 2 ** REG_WIDTH;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Decode issue/writeback strobes into per-register set/clear masks and
  // resolve them against the held state.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_iss_en) begin
      w_set[i_iss_rd] = 1'b1;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w]) begin
        w_clr[i_wr_addr[w*REG_WIDTH +: REG_WIDTH]] = 1'b1;
      end
    end
    w_set[0] = 1'b0;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Pending-bit state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD combinational read ports, NUM_WR synchronous write ports
// and a pending-write scoreboard. x0 is hardwired to zero.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle write data to
// matching read ports and reports them as not busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int NUM_REGS = 2 ** REG_WIDTH;
  localparam logic [REG_WIDTH-1:0] L_ZERO = REG_WIDTH'(REG_ZERO);

  logic [WIDTH-1:0]        r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]     w_busy_vec;
  logic [REG_WIDTH-1:0]    w_ra [NUM_RD];
  logic [NUM_RD*WIDTH-1:0] w_rd_data;
  logic [NUM_RD-1:0]       w_rd_busy;

  regfile_scoreboard #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_WR    (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_iss_en   (bus.iss_en_i),
    .i_iss_rd   (bus.iss_rd_i),
    .i_wr_en    (bus.wr_en_i),
    .i_wr_addr  (bus.wr_addr_i),
    .i_flush    (bus.flush_i),
    .o_busy_vec (w_busy_vec)
  );

  // Commit writes; ports are visited in ascending order so the youngest
  // (highest-index) port wins an address collision. x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en_i[w] && (bus.wr_addr_i[w*REG_WIDTH +: REG_WIDTH] != L_ZERO)) begin
          r_regs[bus.wr_addr_i[w*REG_WIDTH +: REG_WIDTH]] <= bus.wr_data_i[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read muxing: stored value and registered pending bit, optionally
  // overridden by a same-cycle write, forced to zero for x0 and in reset.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_ra      = '{default: '0};
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra[k] = bus.rd_addr_i[k*REG_WIDTH +: REG_WIDTH];
      w_rd_data[k*WIDTH +: WIDTH] = r_regs[w_ra[k]];
      w_rd_busy[k] = w_busy_vec[w_ra[k]];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan: the last match is the youngest write port.
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en_i[w] && (bus.wr_addr_i[w*REG_WIDTH +: REG_WIDTH] == w_ra[k])) begin
          w_rd_data[k*WIDTH +: WIDTH] = bus.wr_data_i[w*WIDTH +: WIDTH];
          w_rd_busy[k] = 1'b0;
        end
      end
`endif
      if ((w_ra[k] == L_ZERO) || !rst) begin
        w_rd_data[k*WIDTH +: WIDTH] = '0;
        w_rd_busy[k] = 1'b0;
      end
    end
  end

  assign bus.rd_data_o  = w_rd_data;
  assign bus.rd_busy_o  = w_rd_busy;
  assign bus.busy_vec_o = w_busy_vec;

endmodule
